// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide engine.
// Shift-add multiply and restoring divide, ITER_BITS bits retired per cycle.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int ITER_BITS = 1
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic            MD_start,
    input  logic [2:0]      MD_funct3,
    input  logic [XLEN-1:0] MD_rs1_data,
    input  logic [XLEN-1:0] MD_rs2_data,
    input  logic [4:0]      MD_tag_in,
    input  logic            MD_flush,
    output logic            MD_busy,
    output logic            MD_done,
    output logic [XLEN-1:0] MD_result,
    output logic [4:0]      MD_tag_out
);
    localparam int N  = XLEN / ITER_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]      op;
    logic [XLEN-1:0] opb, hi, lo;
    logic            neg;
    logic [CW-1:0]   cnt;
    logic [4:0]      tag;
    logic            accept, last;

    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    // Operands are reduced to magnitudes at accept; the sign is reapplied at the end.
    always_comb begin
        is_div = MD_funct3[2];
        a_sgn  = (MD_funct3 == 3'b001) || (MD_funct3 == 3'b010) ||
                 (MD_funct3 == 3'b100) || (MD_funct3 == 3'b110);
        b_sgn  = (MD_funct3 == 3'b001) || (MD_funct3 == 3'b100) ||
                 (MD_funct3 == 3'b110);
        a_neg  = a_sgn && MD_rs1_data[XLEN-1];
        b_neg  = b_sgn && MD_rs2_data[XLEN-1];
        a_mag  = a_neg ? (~MD_rs1_data + 1'b1) : MD_rs1_data;
        b_mag  = b_neg ? (~MD_rs2_data + 1'b1) : MD_rs2_data;
        neg_in = (MD_funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
        special_res = '0;
        special = 1'b0;
        if (is_div && (MD_rs2_data == '0)) begin
            special     = 1'b1;
            special_res = MD_funct3[1] ? MD_rs1_data : '1;
        end else if (is_div && !MD_funct3[0] && (MD_rs1_data == MIN) &&
                     (MD_rs2_data == '1)) begin
            special     = 1'b1;
            special_res = MD_funct3[1] ? '0 : MIN;
        end
    end

    logic [XLEN+ITER_BITS-1:0] acc;
    logic [XLEN:0]             rem;
    logic [XLEN-1:0]           hi_nx, lo_nx;

    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
        acc   = '0;
        rem   = '0;
        if (op[2]) begin
            for (int i = 0; i < ITER_BITS; i++) begin
                rem   = {hi_nx, lo_nx[XLEN-1]};
                lo_nx = {lo_nx[XLEN-2:0], 1'b0};
                if (rem >= {1'b0, opb}) begin
                    rem      = rem - {1'b0, opb};
                    lo_nx[0] = 1'b1;
                end
                hi_nx = rem[XLEN-1:0];
            end
        end else begin
            acc = {{ITER_BITS{1'b0}}, hi};
            for (int i = 0; i < ITER_BITS; i++) begin
                if (lo[i])
                    acc = acc + ({{ITER_BITS{1'b0}}, opb} << i);
            end
            {hi_nx, lo_nx} = {acc, lo[XLEN-1:ITER_BITS]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fin;

    always_comb begin
        prod = {hi_nx, lo_nx};
        if (neg)
            prod = ~prod + 1'b1;
        fin = '0;
        if (op[2]) begin
            fin = op[1] ? hi_nx : lo_nx;
            if (neg)
                fin = ~fin + 1'b1;
        end else begin
            fin = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Flush overrides both a new issue and a completing calculation.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: accept = MD_start;
            CALC: if (last) state_nx = DONE;
            DONE: begin
                state_nx = IDLE;
                accept   = MD_start;
            end
            default: state_nx = IDLE;
        endcase
        if (accept)
            state_nx = special ? DONE : CALC;
        if (MD_flush) begin
            state_nx = IDLE;
            accept   = 1'b0;
        end
    end

    assign MD_busy = (state == CALC);
    assign MD_done = (state == DONE);

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            op         <= '0;
            opb        <= '0;
            hi         <= '0;
            lo         <= '0;
            neg        <= 1'b0;
            cnt        <= '0;
            tag        <= '0;
            MD_result  <= '0;
            MD_tag_out <= '0;
        end else if (accept) begin
            op  <= MD_funct3;
            tag <= MD_tag_in;
            neg <= neg_in;
            cnt <= '0;
            hi  <= '0;
            opb <= is_div ? b_mag : a_mag;
            lo  <= is_div ? a_mag : b_mag;
            if (special) begin
                MD_result  <= special_res;
                MD_tag_out <= MD_tag_in;
            end
        end else if ((state == CALC) && !MD_flush) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                MD_result  <= fin;
                MD_tag_out <= tag;
            end
        end
    end
endmodule
